// File: rtl/wb_cache_pkg.sv
// wb_mem_cache shared definitions.
// State encoding and address slicing.
package wb_cache_pkg;

  localparam int DEF_INDEX_BITS = 4;
  localparam int LINE_WORDS     = 4;
  localparam int WORD_LSB       = 2;
  localparam int IDX_LSB        = 4;
  localparam int DEF_TAG_LSB    = IDX_LSB + DEF_INDEX_BITS;
  localparam int DEF_TAG_W      = 32 - DEF_TAG_LSB;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_GAP   = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/wb_cache_array.sv
// Tag, valid and data storage for the direct-mapped cache.
// Combinational read, byte-enabled word write, global valid clear.
module wb_cache_array
  import wb_cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  input  logic [1:0]            rd_word_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [1:0]            wr_word_i,
  input  logic [3:0]            wr_be_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  tag_en_i,
  input  logic [INDEX_BITS-1:0] tag_idx_i,
  input  logic                  tag_valid_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic                  clr_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

  // Next valid bits: per-line update, global clear wins.
  always_comb begin
    valid_d = valid_q;
    if (tag_en_i) valid_d[tag_idx_i] = tag_valid_i;
    if (clr_i) valid_d = '0;
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data storage writes.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b])
          data_q[wr_idx_i][wr_word_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
    if (tag_en_i) tag_q[tag_idx_i] <= tag_i;
  end

endmodule

// File: rtl/wb_mem_cache.sv
// Direct-mapped write-through read cache between CPU
// Wishbone and the memory controller Wishbone slave.
module wb_mem_cache
  import wb_cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int LINE_WORDS_P = LINE_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  input  logic        s_we_i,
  input  logic [31:0] s_addr_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_data_i,
  output logic [31:0] s_data_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  input  logic        m_ack_i,
  input  logic        inv_i
);

  localparam int TAG_LSB = IDX_LSB + INDEX_BITS;
  localparam int TAG_W   = 32 - TAG_LSB;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        inv_q, inv_d;
  logic [31:2] addr_q, addr_d;
  logic        s_ack_q, s_ack_d;
  logic [31:0] s_data_q, s_data_d;
  logic        m_cyc_q, m_cyc_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_sel_q, m_sel_d;
  logic [31:0] m_data_q, m_data_d;

  logic                  req, hit;
  logic [1:0]            nbeat;
  logic [INDEX_BITS-1:0] s_idx, q_idx;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data;
  logic                  wr_en, tag_en, tag_valid;
  logic [INDEX_BITS-1:0] wr_idx, tag_idx;
  logic [1:0]            wr_word;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic                  unused_ok;

  assign unused_ok = ^{s_addr_i[1:0], LINE_WORDS_P[0]};

  assign req   = s_stb_i & s_cyc_i;
  assign s_idx = s_addr_i[TAG_LSB-1:IDX_LSB];
  assign q_idx = addr_q[TAG_LSB-1:IDX_LSB];
  assign hit   = rd_valid & (rd_tag == s_addr_i[31:TAG_LSB]);
  assign nbeat = beat_q + 2'd1;

  wb_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (s_idx),
    .rd_word_i   (s_addr_i[3:2]),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_word_i   (wr_word),
    .wr_be_i     (wr_be),
    .wr_data_i   (wr_data),
    .tag_en_i    (tag_en),
    .tag_idx_i   (tag_idx),
    .tag_valid_i (tag_valid),
    .tag_i       (addr_q[31:TAG_LSB]),
    .clr_i       (inv_i)
  );

  // Next state, master port and array control.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    inv_d     = inv_q;
    addr_d    = addr_q;
    s_ack_d   = 1'b0;
    s_data_d  = s_data_q;
    m_cyc_d   = m_cyc_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_sel_d   = m_sel_q;
    m_data_d  = m_data_q;
    wr_en     = 1'b0;
    wr_idx    = s_idx;
    wr_word   = s_addr_i[3:2];
    wr_be     = s_sel_i;
    wr_data   = s_data_i;
    tag_en    = 1'b0;
    tag_idx   = q_idx;
    tag_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !s_ack_q) begin
          addr_d = s_addr_i[31:2];
          if (s_we_i) begin
            state_d  = S_WRITE;
            m_cyc_d  = 1'b1;
            m_we_d   = 1'b1;
            m_sel_d  = s_sel_i;
            m_data_d = s_data_i;
            m_addr_d = {s_addr_i[31:2], 2'b00};
            wr_en    = hit;
          end else if (hit) begin
            s_ack_d  = 1'b1;
            s_data_d = rd_data;
          end else begin
            // Drop the victim line before refilling it.
            state_d  = S_FILL;
            beat_d   = 2'd0;
            inv_d    = 1'b0;
            m_cyc_d  = 1'b1;
            m_we_d   = 1'b0;
            m_sel_d  = 4'hF;
            m_addr_d = {s_addr_i[31:4], 4'b0000};
            tag_en   = 1'b1;
            tag_idx  = s_idx;
          end
        end
      end
      S_FILL: begin
        if (inv_i) inv_d = 1'b1;
        if (m_ack_i) begin
          m_cyc_d = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = q_idx;
          wr_word = beat_q;
          wr_be   = 4'hF;
          wr_data = m_data_i;
          if (beat_q == addr_q[3:2]) s_data_d = m_data_i;
          state_d = req ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (inv_i) inv_d = 1'b1;
        if (!req) begin
          state_d = S_IDLE;
        end else if (beat_q == 2'd3) begin
          tag_en    = !(inv_q || inv_i);
          tag_valid = 1'b1;
          s_ack_d   = 1'b1;
          state_d   = S_RESP;
        end else begin
          beat_d   = nbeat;
          m_cyc_d  = 1'b1;
          m_addr_d = {addr_q[31:4], nbeat, 2'b00};
          state_d  = S_FILL;
        end
      end
      S_WRITE: begin
        if (m_ack_i) begin
          m_cyc_d = 1'b0;
          m_we_d  = 1'b0;
          s_ack_d = req;
          state_d = req ? S_RESP : S_IDLE;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      beat_q   <= 2'd0;
      inv_q    <= 1'b0;
      addr_q   <= '0;
      s_ack_q  <= 1'b0;
      s_data_q <= '0;
      m_cyc_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= '0;
      m_sel_q  <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      inv_q    <= inv_d;
      addr_q   <= addr_d;
      s_ack_q  <= s_ack_d;
      s_data_q <= s_data_d;
      m_cyc_q  <= m_cyc_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_sel_q  <= m_sel_d;
      m_data_q <= m_data_d;
    end
  end

  assign s_ack_o  = s_ack_q;
  assign s_data_o = s_data_q;
  assign m_cyc_o  = m_cyc_q;
  assign m_stb_o  = m_cyc_q;
  assign m_we_o   = m_we_q;
  assign m_addr_o = m_addr_q;
  assign m_sel_o  = m_sel_q;
  assign m_data_o = m_data_q;

endmodule

// File: tb/tb_wb_mem_cache.sv
// Directed bench for wb_mem_cache with a
// fixed-latency Wishbone memory model.
module tb_wb_mem_cache;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        s_stb_i, s_cyc_i, s_we_i;
  logic [31:0] s_addr_i, s_data_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_data_o;
  logic        s_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_addr_o, m_data_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_data_i;
  logic        m_ack_i;
  logic        inv_i;

  always #5 clk = ~clk;

  wb_mem_cache dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .s_stb_i  (s_stb_i),
    .s_cyc_i  (s_cyc_i),
    .s_we_i   (s_we_i),
    .s_addr_i (s_addr_i),
    .s_sel_i  (s_sel_i),
    .s_data_i (s_data_i),
    .s_data_o (s_data_o),
    .s_ack_o  (s_ack_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_addr_o (m_addr_o),
    .m_sel_o  (m_sel_o),
    .m_data_o (m_data_o),
    .m_data_i (m_data_i),
    .m_ack_i  (m_ack_i),
    .inv_i    (inv_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Memory contents: a few fixed words, a pattern elsewhere.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hDEAD0000);
  endfunction

  // Downstream slave: ack LAT cycles after strobe, one cycle wide.
  initial begin
    int cnt;
    logic [31:0] w;
    cnt = 0;
    m_ack_i = 1'b0;
    m_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_ack_i) begin
        m_ack_i = 1'b0;
      end else if (m_stb_o && !rst_i) begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          m_ack_i = 1'b1;
          if (m_we_o) begin
            w = mrd(m_addr_o);
            for (int b = 0; b < 4; b++)
              if (m_sel_o[b]) w[8*b +: 8] = m_data_o[8*b +: 8];
            mem[m_addr_o] = w;
          end else begin
            m_data_i = mrd(m_addr_o);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: count downstream strobes, log them, catch stray acks.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          stray = 0;
  logic [31:0] rd_q [$];
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_sel;
  logic        prev_stb = 1'b0;

  initial begin
    wr_addr = '0;
    wr_data = '0;
    wr_sel  = '0;
    forever begin
      @(negedge clk);
      if (m_stb_o && !prev_stb) begin
        if (m_we_o) begin
          wr_cnt++;
          wr_addr = m_addr_o;
          wr_sel  = m_sel_o;
          wr_data = m_data_o;
        end else begin
          rd_cnt++;
          rd_q.push_back(m_addr_o);
        end
      end
      prev_stb = m_stb_o;
      if (s_ack_o && !(s_stb_i && s_cyc_i)) stray++;
      if (m_stb_o !== m_cyc_o) stray++;
    end
  end

  task automatic cpu_txn(input logic we, input logic [31:0] a,
                         input logic [3:0] sel, input logic [31:0] d,
                         output logic [31:0] rd, output int lat,
                         output logic ok);
    s_stb_i  = 1'b1;
    s_cyc_i  = 1'b1;
    s_we_i   = we;
    s_addr_i = a;
    s_sel_i  = sel;
    s_data_i = d;
    ok  = 1'b0;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (s_ack_o) begin
        ok  = 1'b1;
        lat = i;
        rd  = s_data_o;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    s_we_i  = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [31:0] rd;
    int          lat, r0, w0;
    logic        ok, pulsed;

    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          lat, r0, w0;
    logic        ok, pulsed;

    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;
    mem[32'h10C] = 32'h44;

    vt[0] = '{1'b0, 32'h104,      4'hF, 0, 32'h22,       4, 0};
    vt[1] = '{1'b0, 32'h10C,      4'hF, 0, 32'h44,       0, 0};
    vt[2] = '{1'b1, 32'h108,      4'h3, 32'hAABBCCDD, 0, 0, 1};
    vt[3] = '{1'b0, 32'h108,      4'hF, 0, 32'h0000CCDD, 0, 0};
    vt[4] = '{1'b1, 32'h08000000, 4'hF, 32'h12345678, 0, 0, 1};
    vt[5] = '{1'b0, 32'h08000000, 4'hF, 0, 32'h12345678, 4, 0};
    vt[6] = '{1'b0, 32'h104,      4'hF, 0, 32'h22,       4, 0};
    vt[7] = '{1'b0, 32'h108,      4'hF, 0, 32'h0000CCDD, 0, 0};

    rst_i    = 1'b1;
    s_stb_i  = 1'b0;
    s_cyc_i  = 1'b0;
    s_we_i   = 1'b0;
    s_addr_i = '0;
    s_sel_i  = '0;
    s_data_i = '0;
    inv_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_ack", s_ack_o, 0);
    chk("rst m_cyc", m_cyc_o, 0);
    chk("rst m_stb", m_stb_o, 0);
    chk("rst m_we", m_we_o, 0);
    chk("rst m_addr", m_addr_o, 0);
    chk("rst m_sel", m_sel_o, 0);
    chk("rst m_data", m_data_o, 0);
    chk("rst s_data", s_data_o, 0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      cpu_txn(vt[i].we, vt[i].addr, vt[i].sel, vt[i].data, rd, lat, ok);
      chk($sformatf("v%0d ack", i), ok, 1);
      chk($sformatf("v%0d reads", i), rd_cnt - r0, vt[i].exp_reads);
      chk($sformatf("v%0d writes", i), wr_cnt - w0, vt[i].exp_writes);
      if (vt[i].we) begin
        chk($sformatf("v%0d waddr", i), wr_addr, vt[i].addr & ~32'h3);
        chk($sformatf("v%0d wsel", i), wr_sel, vt[i].sel);
        chk($sformatf("v%0d wdata", i), wr_data, vt[i].data);
      end else begin
        chk($sformatf("v%0d data", i), rd, vt[i].exp_rd);
        if (vt[i].exp_reads == 0)
          chk($sformatf("v%0d hit lat", i), lat, 1);
      end
    end

    chk("fill beat0", rd_q[0], 32'h100);
    chk("fill beat1", rd_q[1], 32'h104);
    chk("fill beat2", rd_q[2], 32'h108);
    chk("fill beat3", rd_q[3], 32'h10C);

    // Invalidate while idle: cached line 0x110 must miss afterwards.
    cpu_txn(1'b0, 32'h110, 4'hF, 0, rd, lat, ok);
    r0 = rd_cnt;
    cpu_txn(1'b0, 32'h114, 4'hF, 0, rd, lat, ok);
    chk("pre-inv hit reads", rd_cnt - r0, 0);
    chk("pre-inv hit data", rd, 32'hDEAD0114);
    inv_i = 1'b1;
    @(posedge clk);
    #1;
    inv_i = 1'b0;
    r0 = rd_cnt;
    cpu_txn(1'b0, 32'h114, 4'hF, 0, rd, lat, ok);
    chk("post-inv reads", rd_cnt - r0, 4);
    chk("post-inv data", rd, 32'hDEAD0114);

    // Invalidate during beat 2 of a fill of 0x200.
    r0 = rd_cnt;
    pulsed = 1'b0;
    ok = 1'b0;
    rd = '0;
    s_stb_i  = 1'b1;
    s_cyc_i  = 1'b1;
    s_we_i   = 1'b0;
    s_addr_i = 32'h200;
    s_sel_i  = 4'hF;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      inv_i = (rd_cnt - r0 == 3) && !pulsed;
      if (inv_i) pulsed = 1'b1;
      if (s_ack_o) begin
        ok = 1'b1;
        rd = s_data_o;
        break;
      end
    end
    inv_i = 1'b0;
    @(posedge clk);
    #1;
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    chk("inv fill ack", ok, 1);
    chk("inv pulsed", pulsed, 1);
    chk("inv fill data", rd, 32'hDEAD0200);
    chk("inv fill reads", rd_cnt - r0, 4);
    r0 = rd_cnt;
    cpu_txn(1'b0, 32'h200, 4'hF, 0, rd, lat, ok);
    chk("inv refill reads", rd_cnt - r0, 4);
    chk("inv refill data", rd, 32'hDEAD0200);

    // Reset during beat 1 of a fill of 0x300.
    r0 = rd_cnt;
    s_stb_i  = 1'b1;
    s_cyc_i  = 1'b1;
    s_we_i   = 1'b0;
    s_addr_i = 32'h300;
    s_sel_i  = 4'hF;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rd_cnt - r0 == 2) break;
    end
    chk("pre-rst beat1", rd_cnt - r0, 2);
    chk("pre-rst m_cyc", m_cyc_o, 1);
    rst_i = 1'b1;
    #1;
    chk("async rst m_cyc", m_cyc_o, 0);
    chk("async rst s_ack", s_ack_o, 0);
    @(posedge clk);
    #1;
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    rst_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    r0 = rd_cnt;
    cpu_txn(1'b0, 32'h300, 4'hF, 0, rd, lat, ok);
    chk("post-rst ack", ok, 1);
    chk("post-rst reads", rd_cnt - r0, 4);
    chk("post-rst data", rd, 32'hDEAD0300);

    chk("stray ack/stb", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
